// File: rtl/cpu_pkg.sv
// Shared CPU definitions: load funct3 encodings, writeback FSM states,
// the captured-load payload and the default load timeout.
package cpu_pkg;

  // Load size/sign encodings (funct3 of the LOAD opcode)
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  // Cycles to wait for load data before abandoning the load
  localparam int unsigned WB_TIMEOUT_DEFAULT = 16;

  typedef enum logic [0:0] {
    WB_IDLE = 1'b0,
    WB_WAIT = 1'b1
  } wb_state_e;

  // Load instruction fields kept while waiting for the memory response
  typedef struct packed {
    logic       reg_write;
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [1:0] offset;
  } wb_load_t;

endpackage

// File: rtl/load_align.sv
// Load data aligner: selects the addressed byte/half/word of a memory word
// and sign/zero-extends it; flags offset/funct3 combinations that are illegal.
// Ports:
//   funct3     - load size/sign encoding
//   offset     - byte offset within the word (address[1:0])
//   rdata      - raw word from data memory
//   data       - aligned, extended load value (combinational)
//   misaligned - offset illegal for the size, or unsupported funct3 (combinational)
module load_align
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data,
  output logic            misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection
  always_comb begin
    case (offset)
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
  end

  // Extension and legality
  always_comb begin
    data       = '0;
    misaligned = 1'b0;
    case (funct3)
      LB:  data = XLEN'($signed(byte_sel));
      LBU: data = XLEN'(byte_sel);
      LH: begin
        data       = XLEN'($signed(half_sel));
        misaligned = offset[0];
      end
      LHU: begin
        data       = XLEN'(half_sel);
        misaligned = offset[0];
      end
      LW: begin
        data       = rdata;
        misaligned = (offset != 2'd0);
      end
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_writeback_unit.sv
// MEM/WB pipeline register and writeback sequencer. Accepts retiring
// instructions from MEM, waits for data-memory responses on loads (holding
// off MEM via in_ready) and issues one register-file write per instruction.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   flush             - drop pending/incoming instruction
//   in_valid/in_ready - MEM handshake (in_ready is combinational)
//   in_*              - retiring instruction fields
//   mem_rvalid/rdata  - data-memory load response
//   RegWrite/WriteAddr/WriteData - registered register-file write port
//   err_misaligned/err_timeout/err_spurious - registered one-cycle error pulses
module wb_writeback_unit
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT = WB_TIMEOUT_DEFAULT,
  parameter int unsigned XLEN    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_reg_write,
  input  logic [4:0]      in_rd,
  input  logic            in_mem_to_reg,
  input  logic            in_link,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic [XLEN-1:0] in_pc4,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            RegWrite,
  output logic [4:0]      WriteAddr,
  output logic [XLEN-1:0] WriteData,
  output logic            err_misaligned,
  output logic            err_timeout,
  output logic            err_spurious
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  wb_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  wb_load_t         ld_q, ld_d;

  logic             regwrite_d;
  logic [4:0]       waddr_d;
  logic [XLEN-1:0]  wdata_d;
  logic             err_mis_d, err_to_d, err_sp_d;

  logic [XLEN-1:0]  align_data;
  logic             align_mis;
  logic             accept;

  assign in_ready = (state_q == WB_IDLE) && !flush;
  assign accept   = in_valid && in_ready;

  load_align #(.XLEN(XLEN)) u_load_align (
    .funct3     (ld_q.funct3),
    .offset     (ld_q.offset),
    .rdata      (mem_rdata),
    .data       (align_data),
    .misaligned (align_mis)
  );

  // State and output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= WB_IDLE;
      cnt_q          <= '0;
      ld_q           <= '0;
      RegWrite       <= 1'b0;
      WriteAddr      <= '0;
      WriteData      <= '0;
      err_misaligned <= 1'b0;
      err_timeout    <= 1'b0;
      err_spurious   <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      ld_q           <= ld_d;
      RegWrite       <= regwrite_d;
      WriteAddr      <= waddr_d;
      WriteData      <= wdata_d;
      err_misaligned <= err_mis_d;
      err_timeout    <= err_to_d;
      err_spurious   <= err_sp_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ld_d       = ld_q;
    regwrite_d = 1'b0;
    waddr_d    = WriteAddr;
    wdata_d    = WriteData;
    err_mis_d  = 1'b0;
    err_to_d   = 1'b0;
    err_sp_d   = 1'b0;

    case (state_q)
      WB_IDLE: begin
        err_sp_d = mem_rvalid;
        if (accept) begin
          if (in_mem_to_reg) begin
            ld_d.reg_write = in_reg_write;
            ld_d.rd        = in_rd;
            ld_d.funct3    = in_funct3;
            ld_d.offset    = in_alu_result[1:0];
            cnt_d          = '0;
            state_d        = WB_WAIT;
          end else begin
            regwrite_d = in_reg_write && (in_rd != 5'd0);
            waddr_d    = in_rd;
            wdata_d    = in_link ? in_pc4 : in_alu_result;
          end
        end
      end

      WB_WAIT: begin
        if (flush) begin
          state_d = WB_IDLE;
          cnt_d   = '0;
        end else if (mem_rvalid) begin
          state_d = WB_IDLE;
          cnt_d   = '0;
          if (align_mis) begin
            // Illegal load: report it, leave the write port untouched
            err_mis_d = 1'b1;
          end else begin
            regwrite_d = ld_q.reg_write && (ld_q.rd != 5'd0);
            waddr_d    = ld_q.rd;
            wdata_d    = align_data;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d  = WB_IDLE;
          cnt_d    = '0;
          err_to_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = WB_IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_writeback_unit.sv
// Self-checking bench for wb_writeback_unit: table of ALU/link writes,
// hand-written load/timeout/flush/reset sequences and a randomized run, all
// checked against a transaction-level reference model.
module tb_wb_writeback_unit;

  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned XLEN    = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic            in_reg_write;
  logic [4:0]      in_rd;
  logic            in_mem_to_reg;
  logic            in_link;
  logic [2:0]      in_funct3;
  logic [XLEN-1:0] in_alu_result;
  logic [XLEN-1:0] in_pc4;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;
  logic            RegWrite;
  logic [4:0]      WriteAddr;
  logic [XLEN-1:0] WriteData;
  logic            err_misaligned;
  logic            err_timeout;
  logic            err_spurious;

  wb_writeback_unit #(.TIMEOUT(TIMEOUT), .XLEN(XLEN)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_reg_write   (in_reg_write),
    .in_rd          (in_rd),
    .in_mem_to_reg  (in_mem_to_reg),
    .in_link        (in_link),
    .in_funct3      (in_funct3),
    .in_alu_result  (in_alu_result),
    .in_pc4         (in_pc4),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .RegWrite       (RegWrite),
    .WriteAddr      (WriteAddr),
    .WriteData      (WriteData),
    .err_misaligned (err_misaligned),
    .err_timeout    (err_timeout),
    .err_spurious   (err_spurious)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: whether a load is outstanding, how long it has waited,
  // and what the write port / error outputs should show after each edge.
  bit          m_busy;
  int          m_waited;
  bit          m_we;
  logic [4:0]  m_rd;
  int          m_f3;
  int          m_off;
  bit          e_rw, e_mis, e_to, e_sp;
  logic [4:0]  e_addr;
  logic [31:0] e_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_waited = 0;
    e_rw = 0; e_mis = 0; e_to = 0; e_sp = 0;
    e_addr = '0; e_data = '0;
  endtask

  // Value a load of the given size/sign at the given byte offset returns
  task automatic ref_load(input int f3, input int off, input logic [31:0] word,
                          output logic [31:0] val, output bit bad);
    int     size;
    bit     is_unsigned;
    longint v, mask;
    size        = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : (f3 == 2) ? 4 : 0;
    is_unsigned = (f3 >= 4);
    bad = 0;
    if (size == 0) bad = 1;
    else if (off % size != 0) bad = 1;
    v = longint'(word) >> (8 * off);
    if (size == 0) size = 4;
    mask = (longint'(1) << (8 * size)) - 1;
    v = v & mask;
    if (!is_unsigned && size < 4 && v >= (longint'(1) << (8 * size - 1)))
      v = v - (longint'(1) << (8 * size));
    val = 32'(v);
  endtask

  task automatic model_edge();
    logic [31:0] val;
    bit          bad;
    e_rw = 0; e_mis = 0; e_to = 0; e_sp = 0;
    if (!m_busy) begin
      if (mem_rvalid) e_sp = 1;
      if (in_valid && !flush) begin
        if (in_mem_to_reg) begin
          m_busy = 1; m_waited = 0;
          m_we = in_reg_write; m_rd = in_rd;
          m_f3 = int'(in_funct3); m_off = int'(in_alu_result % 4);
        end else begin
          e_rw   = in_reg_write && (in_rd != 0);
          e_addr = in_rd;
          e_data = in_link ? in_pc4 : in_alu_result;
        end
      end
    end else if (flush) begin
      m_busy = 0;
    end else if (mem_rvalid) begin
      ref_load(m_f3, m_off, mem_rdata, val, bad);
      m_busy = 0;
      if (bad) e_mis = 1;
      else begin
        e_rw = m_we && (m_rd != 0); e_addr = m_rd; e_data = val;
      end
    end else begin
      m_waited++;
      if (m_waited == TIMEOUT) begin
        e_to = 1; m_busy = 0;
      end
    end
  endtask

  // One clock: check in_ready, take the edge, check registered outputs
  task automatic step();
    #1;
    chk("in_ready", 32'(in_ready), 32'(!m_busy && !flush));
    @(posedge clk);
    model_edge();
    #1;
    chk("RegWrite", 32'(RegWrite), 32'(e_rw));
    chk("WriteAddr", 32'(WriteAddr), 32'(e_addr));
    chk("WriteData", WriteData, e_data);
    chk("err_misaligned", 32'(err_misaligned), 32'(e_mis));
    chk("err_timeout", 32'(err_timeout), 32'(e_to));
    chk("err_spurious", 32'(err_spurious), 32'(e_sp));
  endtask

  task automatic idle_inputs();
    flush = 0; in_valid = 0; in_reg_write = 0; in_rd = '0; in_mem_to_reg = 0;
    in_link = 0; in_funct3 = '0; in_alu_result = '0; in_pc4 = '0;
    mem_rvalid = 0; mem_rdata = '0;
  endtask

  // Present a load, then wait 'waits' cycles before returning 'word'
  task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd,
                         input int waits, input logic [31:0] word);
    idle_inputs();
    in_valid = 1; in_mem_to_reg = 1; in_reg_write = 1; in_rd = rd;
    in_funct3 = f3; in_alu_result = addr;
    step();
    idle_inputs();
    for (int i = 0; i < waits; i++) begin
      step();
      chk("in_ready_wait", 32'(in_ready), 32'd0);
    end
    mem_rvalid = 1; mem_rdata = word;
    step();
    idle_inputs();
  endtask

  typedef struct {
    logic        reg_write;
    logic [4:0]  rd;
    logic        link;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic        exp_rw;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{1'b1, 5'd5,  1'b0, 32'h0000_1234, 32'h0,     1'b1, 5'd5,  32'h0000_1234};
    vecs[1] = '{1'b1, 5'd1,  1'b1, 32'h0000_dead, 32'h104,   1'b1, 5'd1,  32'h0000_0104};
    vecs[2] = '{1'b1, 5'd0,  1'b1, 32'h0000_0055, 32'h108,   1'b0, 5'd0,  32'h0000_0108};
    vecs[3] = '{1'b0, 5'd7,  1'b0, 32'h0000_abcd, 32'h0,     1'b0, 5'd7,  32'h0000_abcd};
    vecs[4] = '{1'b1, 5'd31, 1'b0, 32'hffff_ffff, 32'h0,     1'b1, 5'd31, 32'hffff_ffff};
    vecs[5] = '{1'b1, 5'd2,  1'b1, 32'h0000_0000, 32'h200,   1'b1, 5'd2,  32'h0000_0200};

    idle_inputs();
    rst = 1;
    model_reset();
    #12;
    chk("reset_RegWrite", 32'(RegWrite), 32'd0);
    chk("reset_WriteAddr", 32'(WriteAddr), 32'd0);
    chk("reset_WriteData", WriteData, 32'd0);
    chk("reset_errs", {29'd0, err_misaligned, err_timeout, err_spurious}, 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 0;
    step();

    // Back-to-back ALU / link writes from the table
    for (int i = 0; i < 6; i++) begin
      idle_inputs();
      in_valid = 1; in_reg_write = vecs[i].reg_write; in_rd = vecs[i].rd;
      in_link = vecs[i].link; in_alu_result = vecs[i].alu; in_pc4 = vecs[i].pc4;
      step();
      chk("tbl_RegWrite", 32'(RegWrite), 32'(vecs[i].exp_rw));
      chk("tbl_WriteAddr", 32'(WriteAddr), 32'(vecs[i].exp_addr));
      chk("tbl_WriteData", WriteData, vecs[i].exp_data);
    end
    idle_inputs();
    step();
    chk("tbl_drop", 32'(RegWrite), 32'd0);
    chk("tbl_hold", WriteData, 32'h0000_0200);

    // LB at offset 3 after three wait cycles
    do_load(3'b000, 32'h0000_1003, 5'd3, 3, 32'h80FF_FFFF);
    chk("lb_RegWrite", 32'(RegWrite), 32'd1);
    chk("lb_WriteAddr", 32'(WriteAddr), 32'd3);
    chk("lb_WriteData", WriteData, 32'hFFFF_FF80);

    // LHU at offset 2
    do_load(3'b101, 32'h0000_2002, 5'd4, 0, 32'h8001_AAAA);
    chk("lhu_WriteData", WriteData, 32'h0000_8001);

    // Misaligned LW
    do_load(3'b010, 32'h0000_1002, 5'd6, 0, 32'h1234_5678);
    chk("mis_err", 32'(err_misaligned), 32'd1);
    chk("mis_RegWrite", 32'(RegWrite), 32'd0);
    #1;
    chk("mis_in_ready", 32'(in_ready), 32'd1);
    step();
    chk("mis_pulse_end", 32'(err_misaligned), 32'd0);

    // Timeout: no response for TIMEOUT cycles, then a stray response
    idle_inputs();
    in_valid = 1; in_mem_to_reg = 1; in_reg_write = 1; in_rd = 5'd7; in_funct3 = 3'b010;
    step();
    idle_inputs();
    for (int i = 0; i < int'(TIMEOUT); i++) begin
      step();
      chk("to_pulse", 32'(err_timeout), 32'(i == int'(TIMEOUT) - 1));
    end
    chk("to_RegWrite", 32'(RegWrite), 32'd0);
    mem_rvalid = 1; mem_rdata = 32'hCAFE_F00D;
    step();
    chk("spurious", 32'(err_spurious), 32'd1);
    idle_inputs();
    step();

    // Flush wins over a same-cycle response
    idle_inputs();
    in_valid = 1; in_mem_to_reg = 1; in_reg_write = 1; in_rd = 5'd8; in_funct3 = 3'b010;
    step();
    idle_inputs();
    step();
    flush = 1; mem_rvalid = 1; mem_rdata = 32'h1111_2222;
    step();
    chk("flush_RegWrite", 32'(RegWrite), 32'd0);
    chk("flush_errs", {29'd0, err_misaligned, err_timeout, err_spurious}, 32'd0);
    idle_inputs();
    #1;
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    step();

    // Asynchronous reset while a load is outstanding
    do_load(3'b010, 32'h0000_0040, 5'd9, 0, 32'h5A5A_5A5A);
    idle_inputs();
    in_valid = 1; in_mem_to_reg = 1; in_reg_write = 1; in_rd = 5'd10; in_funct3 = 3'b010;
    step();
    idle_inputs();
    step();
    #2;
    rst = 1;
    #1;
    model_reset();
    chk("rst_RegWrite", 32'(RegWrite), 32'd0);
    chk("rst_WriteData", WriteData, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 0;
    step();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      int rv_mod;
      rv_mod = (i < 1500) ? 3 : 12;
      flush         = ($urandom % 16) == 0;
      in_valid      = ($urandom % 4) != 0;
      in_reg_write  = ($urandom % 5) != 0;
      in_rd         = 5'($urandom);
      in_mem_to_reg = ($urandom % 3) == 0;
      in_link       = ($urandom % 4) == 0;
      in_funct3     = ($urandom % 4 == 0) ? 3'($urandom) : (($urandom % 2) ? 3'b000 : 3'b101);
      in_alu_result = $urandom;
      in_pc4        = $urandom;
      mem_rvalid    = ($urandom % rv_mod) == 0;
      mem_rdata     = $urandom;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
